// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   - REG_DATA_WIDTH : register/data word width macro, reused as DATA_WIDTH
//   - LANES          : number of byte lanes in a data word
//   - dmem_state_e   : responder FSM state encoding
//   - lane_mask()    : expands a byte-lane select into a bit mask
// ---------------------------------------------------------------------------
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package dmem_responder_pkg;

  localparam int LANES = `REG_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  function automatic logic [`REG_DATA_WIDTH-1:0] lane_mask(input logic [LANES-1:0] sel);
    logic [`REG_DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_ram_bytes.sv
// ---------------------------------------------------------------------------
// dmem_ram_bytes
// Single-port (1RW) synchronous RAM with per-byte write mask and registered
// read data. Kept behind this narrow interface so a vendor block RAM can be
// dropped in without touching the responder.
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable for this cycle
//   we     in   1 = write selected lanes, 0 = read word into rdata
//   addr   in   word index
//   wmask  in   byte-lane write enables
//   wdata  in   write data, lane-aligned
//   rdata  out  registered read data (updated only on enabled reads)
// ---------------------------------------------------------------------------
module dmem_ram_bytes
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int NLANES     = LANES
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [NLANES-1:0]       wmask,
  input  logic [8*NLANES-1:0]     wdata,
  output logic [8*NLANES-1:0]     rdata
);

  logic [8*NLANES-1:0] mem_q [2**ADDR_WIDTH];
  logic [8*NLANES-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NLANES; i++) begin
          if (wmask[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the MIPS memory-access stage. Accepts one word
// request over a valid/ready channel, waits WAIT_CYCLES cycles, commits the
// access to the RAM on the edge entering RESP and pulses resp_valid for one
// cycle. Loads return selected lanes, unselected lanes zero.
// Optional build macro: DMEM_RANGE_CHECK_EN enables out-of-range and
// misalignment checking (resp_err); without it addresses alias and
// resp_err is tied 0.
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_sel      byte-lane enables
//   req_wdata    store data, lane-aligned
//   resp_valid   one-cycle response pulse
//   resp_rdata   load data (0 for stores, errors and outside resp_valid)
//   resp_err     access error flag during resp_valid
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = `REG_DATA_WIDTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [LANES-1:0]      req_sel,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int CNT_W = 4;

  dmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, valid_q, err_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [LANES-1:0]      sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept, chk_err, in_idle, commit;
  logic                  c_we, c_err;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [LANES-1:0]      c_sel;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // ready_q holds the post-reset IDLE value; gating with rst_n keeps the
  // channel closed for as long as reset is held.
  assign req_ready = ready_q & rst_n;
  assign accept    = req_valid & req_ready;

`ifdef DMEM_RANGE_CHECK_EN
  assign chk_err = (req_addr[31:ADDR_WIDTH+2] != '0)
                || ((req_sel == 4'b1111) && (req_addr[1:0] != 2'b00))
                || (((req_sel == 4'b0011) || (req_sel == 4'b1100)) && req_addr[0]);
  assign resp_err = err_q & valid_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
  assign chk_err  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = DMEM_RESP;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES)) state_d = DMEM_RESP;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      DMEM_RESP: begin
        state_d = DMEM_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = DMEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == DMEM_IDLE);
      valid_q <= (state_d == DMEM_RESP);
      if (accept) err_q <= chk_err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_addr[ADDR_WIDTH+1:2];
      sel_q   <= req_sel;
      wdata_q <= req_wdata;
    end
  end

  // With zero wait states the commit edge is the accept edge, so the RAM
  // must see the live request rather than the captured copy.
  assign in_idle = (state_q == DMEM_IDLE);
  assign c_we    = in_idle ? req_we                      : we_q;
  assign c_idx   = in_idle ? req_addr[ADDR_WIDTH+1:2]    : idx_q;
  assign c_sel   = in_idle ? req_sel                     : sel_q;
  assign c_wdata = in_idle ? req_wdata                   : wdata_q;
  assign c_err   = in_idle ? chk_err                     : err_q;

  // A reset on the commit edge abandons the access, including its store.
  assign commit = rst_n & (state_q != DMEM_RESP) & (state_d == DMEM_RESP);

  dmem_ram_bytes #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NLANES     (LANES)
  ) u_ram (
    .clk   (clk),
    .en    (commit),
    .we    (c_we & ~c_err),
    .addr  (c_idx),
    .wmask (c_sel),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  assign resp_valid = valid_q;
  assign resp_rdata = (valid_q & ~we_q & ~err_q) ? (ram_rdata & lane_mask(sel_q)) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int WA = 1;
  localparam int WB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [3:0]  req_sel    [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_sel(req_sel[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_sel(req_sel[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a DUT pulses resp_valid.
  task automatic mon(input int d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp dut%0d: resp_valid=1 at cycle %0d, none expected", d, cyc);
    end else begin
      chk32($sformatf("rdata dut%0d", d), resp_rdata[d], e.rdata);
      chk32($sformatf("err dut%0d", d), {31'b0, resp_err[d]}, {31'b0, e.err});
      chk32($sformatf("resp_cycle dut%0d", d), cyc, e.cyc);
    end
    chk32($sformatf("ready_low_in_resp dut%0d", d), {31'b0, req_ready[d]}, 32'h0);
  endtask

  always @(negedge clk) if (resp_valid[0] === 1'b1) mon(0);
  always @(negedge clk) if (resp_valid[1] === 1'b1) mon(1);

  // Presents a request, waits (bounded) for the accept edge and pushes the
  // expected response. req_valid is left high.
  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, output int acc);
    exp_t e;
    int   n;
    n = 0;
    req_we[d] = we; req_addr[d] = addr; req_sel[d] = sel; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[d] !== 1'b1 && n < 50);
    if (req_ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b after %0d cycles, expected 1", d, req_ready[d], n);
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc     = cyc;
    e.rdata = er;
    e.err   = ee;
    e.cyc   = acc + ((d == 0) ? WA : WB);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: %0d/%0d responses outstanding, expected 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int d, input logic we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
    int acc;
    issue(d, we, addr, sel, wd, er, ee, acc);
    req_valid[d] = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_sel[i] = '0; req_wdata[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk32($sformatf("rst_ready dut%0d", i), {31'b0, req_ready[i]}, 32'h0);
      chk32($sformatf("rst_resp_valid dut%0d", i), {31'b0, resp_valid[i]}, 32'h0);
      chk32($sformatf("rst_rdata dut%0d", i), resp_rdata[i], 32'h0);
      chk32($sformatf("rst_err dut%0d", i), {31'b0, resp_err[i]}, 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk32($sformatf("release_ready dut%0d", i), {31'b0, req_ready[i]}, 32'h1);
    @(posedge clk);
    #1;

    // Full-word store and load, one wait state
    xfer(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store, full load, half load
    xfer(0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);
    xfer(0, 1'b0, 32'h10, 4'b0011, 32'h0, 32'h0000BEEF, 1'b0);

    // sel=0: response issued, no data, no memory change
    xfer(0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);

    // Zero wait states, req_valid held across three requests
    issue(1, 1'b1, 32'h20, 4'b1111, 32'hA5A5A5A5, 32'h0, 1'b0, a0);
    issue(1, 1'b1, 32'h24, 4'b1111, 32'h5A5A5A5A, 32'h0, 1'b0, a1);
    issue(1, 1'b0, 32'h20, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0, a2);
    req_valid[1] = 1'b0;
    chk32("b2b_spacing_1", a1 - a0, 32'd2);
    chk32("b2b_spacing_2", a2 - a1, 32'd2);
    drain();
    xfer(1, 1'b0, 32'h24, 4'b1111, 32'h0, 32'h5A5A5A5A, 1'b0);

    // Reset during WAIT of a store: abandoned, no response, memory unchanged
    req_we[0] = 1'b1; req_addr[0] = 32'h10; req_sel[0] = 4'b1111;
    req_wdata[0] = 32'h12345678; req_valid[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[0] !== 1'b1 && n < 50);
    chk32("midreset_accept_ready", {31'b0, req_ready[0]}, 32'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk32("midreset_ready_after", {31'b0, req_ready[0]}, 32'h1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);

    xfer(0, 1'b1, 32'h0, 4'b1111, 32'h01234567, 32'h0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
    // Out-of-range store suppressed; misaligned word load flagged
    xfer(0, 1'b1, 32'h00001000, 4'b1111, 32'h89ABCDEF, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h01234567, 1'b0);
    xfer(0, 1'b0, 32'h12, 4'b1111, 32'h0, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);
`else
    // Aliasing: high address bits and byte offset ignored
    xfer(0, 1'b1, 32'h1010, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);
    xfer(0, 1'b0, 32'h13, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);
    xfer(0, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h01234567, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
